// File: rtl/serial_subtractor.sv
// Bit-serial a - b, one bit per clock LSB first, behind a start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               borrow_out_q, borrow_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               bit_x, bit_y, bit_bin, bit_d, bit_bout;
  logic [WIDTH-1:0]   res_next;

  // Full-subtractor slice on the current LSBs plus the carried borrow.
  always_comb begin
    bit_x    = a_sh_q[0];
    bit_y    = b_sh_q[0];
    bit_bin  = borrow_q;
    bit_d    = bit_x ^ bit_y ^ bit_bin;
    bit_bout = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & bit_bin);
    res_next = (res_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
  end

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d        = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d    = res_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = bit_bout;
        cnt_d    = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // MSB step: publish the full result and the final borrow.
          diff_d       = res_next;
          borrow_out_d = bit_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d        = (bit_x ^ bit_y) & (bit_d ^ bit_x);
`endif
          cnt_d        = '0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule
